// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SLL / SRL / SRA / ROR) with valid/ready
// handshakes on both ends and a sideband tag carried alongside each operation.
//
// The shift is split into log2(WIDTH) mux levels, largest amount first. Each
// level k shifts by 2^k when sa[k] is set. REG_EVERY levels are grouped into one
// pipeline stage, giving S = ceil(log2(WIDTH)/REG_EVERY) stages and S cycles of
// latency. Stage i advances when it is empty or the next stage advances, and the
// last stage advances on out_ready. Throughput is one operation per cycle.
//
// Optional feature macro: SHIFTER_PIPE_FLAGS_EN adds the out_carry / out_zero
// flag ports and their logic. Without it the ports and flag logic are absent.
//
// Parameters:
//   WIDTH      operand width, power of two, 8..64
//   REG_EVERY  mux levels per pipeline stage, 1..log2(WIDTH)
//   TAG_W      sideband tag width
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation can be accepted this cycle
//   in_data    operand
//   in_sa      shift amount (modulo WIDTH by construction)
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     sideband tag
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_data   shift result
//   out_tag    tag of the result
//   out_carry  last bit shifted out (SHIFTER_PIPE_FLAGS_EN only)
//   out_zero   out_data == 0 (SHIFTER_PIPE_FLAGS_EN only)

module shifter_pipe #(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 4
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_sa,
   input  logic [1:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag
`ifdef SHIFTER_PIPE_FLAGS_EN
   ,
   output logic                     out_carry,
   output logic                     out_zero
`endif
);

   localparam int LOG2 = $clog2(WIDTH);
   localparam int S    = (LOG2 + REG_EVERY - 1) / REG_EVERY;

   logic [S-1:0] v_vec;
   logic [S-1:0] adv_vec;

   // One mux level: shift by 2^k. SRA fill comes from the operand MSB that was
   // sampled at stage 0 and carried along the pipe.
   function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d,
                                            input logic [1:0]       op,
                                            input logic             msb,
                                            input int               k);
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] fill;
      int               sh;
      sh   = 1 << k;
      fill = ~({WIDTH{1'b1}} >> sh);
      case (op)
         2'b00:   r = d << sh;
         2'b01:   r = d >> sh;
         2'b10:   r = (d >> sh) | (msb ? fill : '0);
         default: r = (d >> sh) | (d << (WIDTH - sh));
      endcase
      return r;
   endfunction

`ifdef SHIFTER_PIPE_FLAGS_EN
   // Carry is the last bit shifted out; it only depends on the original operand,
   // so it is resolved at the input. For ROR the bit landing in out_data MSB is
   // X[sa-1], the same bit position as for the right shifts.
   logic            carry0;
   logic [LOG2:0]   cidx;
   always_comb begin
      carry0 = 1'b0;
      cidx   = '0;
      if (in_sa != '0) begin
         if (in_op == 2'b00)
            cidx = (LOG2+1)'(WIDTH) - {1'b0, in_sa};
         else
            cidx = {1'b0, in_sa} - (LOG2+1)'(1);
         carry0 = |(in_data & ({{(WIDTH-1){1'b0}}, 1'b1} << cidx));
      end
   end
`endif

   for (genvar g = 0; g < S; g++) begin : g_st
      // Levels handled here: K_HI down to K_LO. sa bits below K_LO travel on.
      localparam int K_HI = LOG2 - 1 - g * REG_EVERY;
      localparam int K_LO = (K_HI - REG_EVERY + 1 > 0) ? (K_HI - REG_EVERY + 1) : 0;
      localparam int NL   = K_HI - K_LO + 1;

      logic [WIDTH-1:0] d_i, d_n, d_q;
      logic [K_HI:0]    sa_i;
      logic [1:0]       op_i;
      logic             msb_i;
      logic             v_i, v_q;
      logic [TAG_W-1:0] tag_i, tag_q;
      logic [WIDTH-1:0] lv [NL+1];
`ifdef SHIFTER_PIPE_FLAGS_EN
      logic             c_i, c_q;
`endif

      if (g == 0) begin : g_head
         assign d_i   = in_data;
         assign sa_i  = in_sa;
         assign op_i  = in_op;
         assign msb_i = in_data[WIDTH-1];
         assign v_i   = in_valid;
         assign tag_i = in_tag;
`ifdef SHIFTER_PIPE_FLAGS_EN
         assign c_i   = carry0;
`endif
      end else begin : g_link
         assign d_i   = g_st[g-1].d_q;
         assign sa_i  = g_st[g-1].g_ctl.sa_q;
         assign op_i  = g_st[g-1].g_ctl.op_q;
         assign msb_i = g_st[g-1].g_ctl.msb_q;
         assign v_i   = g_st[g-1].v_q;
         assign tag_i = g_st[g-1].tag_q;
`ifdef SHIFTER_PIPE_FLAGS_EN
         assign c_i   = g_st[g-1].c_q;
`endif
      end

      assign lv[0] = d_i;
      for (genvar j = 0; j < NL; j++) begin : g_lvl
         assign lv[j+1] = sa_i[K_HI-j] ? lvl(lv[j], op_i, msb_i, K_HI - j) : lv[j];
      end
      assign d_n = lv[NL];

      // Stage advances if any stage from here to the output is empty, or the
      // consumer is taking the result. Written flat to avoid a combinational chain.
      assign v_vec[g]   = v_q;
      assign adv_vec[g] = out_ready || !(&v_vec[S-1:g]);

      always_ff @(posedge clk or negedge clrn) begin
         if (!clrn) begin
            v_q   <= 1'b0;
            d_q   <= '0;
            tag_q <= '0;
`ifdef SHIFTER_PIPE_FLAGS_EN
            c_q   <= 1'b0;
`endif
         end else if (adv_vec[g]) begin
            v_q   <= v_i;
            d_q   <= d_n;
            tag_q <= tag_i;
`ifdef SHIFTER_PIPE_FLAGS_EN
            c_q   <= c_i;
`endif
         end
      end

      // Control fields are only needed by later stages, so the last stage has none.
      if (g < S - 1) begin : g_ctl
         logic [K_LO-1:0] sa_q;
         logic [1:0]      op_q;
         logic            msb_q;
         always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
               sa_q  <= '0;
               op_q  <= 2'b00;
               msb_q <= 1'b0;
            end else if (adv_vec[g]) begin
               sa_q  <= sa_i[K_LO-1:0];
               op_q  <= op_i;
               msb_q <= msb_i;
            end
         end
      end
   end

   assign in_ready  = adv_vec[0];
   assign out_valid = g_st[S-1].v_q;
   assign out_data  = g_st[S-1].d_q;
   assign out_tag   = g_st[S-1].tag_q;

`ifdef SHIFTER_PIPE_FLAGS_EN
   logic z_q;
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         z_q <= 1'b0;
      else if (adv_vec[S-1])
         z_q <= (g_st[S-1].d_n == '0);
   end
   assign out_carry = g_st[S-1].c_q;
   assign out_zero  = z_q;
`endif

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter for the integer datapath. It performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand using log2(WIDTH) mux levels, largest shift amount first. Pipeline registers sit between levels, and valid/ready handshakes at both ends carry a sideband tag. It replaces the single-cycle combinational shifter in multi-cycle and pipelined EX stages where the shifter is on the critical path.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, 8..64.
- REG_EVERY, 1: number of mux levels per pipeline stage, 1..log2(WIDTH).
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation offered.
- in_ready  out  1  shifter can accept the offered operation this cycle.
- in_data  in  WIDTH  operand X.
- in_sa  in  log2(WIDTH)  shift amount.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  shift result.
- out_tag  out  TAG_W  tag of the result.
- out_carry, out_zero  out  1 each  flags; present only with SHIFTER_PIPE_FLAGS_EN.

## Operation
- Number of pipeline stages S = ceil(log2(WIDTH)/REG_EVERY).
- Level k (k = log2(WIDTH)-1 down to 0) shifts by 2^k when in_sa[k] = 1.
- Level groups are assigned to stages in order. Each stage ends in a register holding data, the remaining sa bits, op, tag, and a valid bit.
- Left shift fills with 0.
- SRL fills with 0.
- SRA fills with the operand MSB, sampled at stage 0 and carried down the pipe.
- ROR re-inserts the bits shifted out.
- sa = 0 returns the operand unchanged for every op.
- Shift amount is modulo WIDTH by construction; there is no overflow or saturation.
- Handshake, per stage i: advance_i = !valid_i || advance_(i+1). The advance term for the last stage is out_ready.
- in_ready = advance_0.
- A transfer occurs on a rising edge when valid and ready are both high on that side.
- Results leave in strict input order; no operation is dropped or duplicated.
- While out_valid = 1 and out_ready = 0, out_data, out_tag and the flags hold stable. out_valid stays high.
- Full pipe: all S valid bits set and out_ready = 0 gives in_ready = 0.
- Simultaneous accept at the input and emit at the output in a full pipe is allowed. Throughput is 1 operation per cycle.
- in_valid = 0 inserts a bubble. Bubbles collapse when a downstream stage stalls.

## Timing
- Latency: S cycles from the input transfer edge to out_valid.
  - WIDTH=32, REG_EVERY=1 gives S=5.
  - REG_EVERY=5 gives S=1.
- in_ready is combinational from out_ready and the valid bits. There is no path from in_valid to in_ready.
- On clrn low: all valid bits go to 0 immediately, so out_valid = 0. Data, tag and flag registers go to 0.
- While clrn is low, in_ready = 1.
- Reset mid-operation discards every in-flight operation. After release, out_valid stays 0 until a new input has traversed S stages.

## Configuration
- SHIFTER_PIPE_FLAGS_EN defined: out_carry and out_zero exist and are pipelined with the data.
  - out_carry is the last bit shifted out:
    - SLL: X[WIDTH-sa].
    - SRL and SRA: X[sa-1].
    - ROR: out_data[WIDTH-1].
    - 0 when sa = 0.
  - out_carry is computed at stage 0.
  - out_zero = (out_data == 0), registered in the final stage.
- SHIFTER_PIPE_FLAGS_EN undefined: both ports and all flag logic are absent. Data behaviour and latency are identical.

## Test plan
WIDTH=32, REG_EVERY=1, S=5 unless noted.
- SRA 0x80000000 by 4, tag 3 -> 0xF8000000, tag 3, out_valid exactly 5 cycles after accept. SRL by the same amount -> 0x08000000.
- ROR 0x12345678 by 8 -> 0x78123456. SLL 0x00000001 by 31 -> 0x80000000, carry 0. SLL 0xFFFFFFFF by 1 -> 0xFFFFFFFE, carry 1. SRL 0x1 by 1 -> 0, zero 1, carry 1.
- sa=0 for all four ops with 0xA5A5A5A5 -> 0xA5A5A5A5, carry 0.
- Back-to-back stream of 10 ops with tags 0..9; out_ready low for cycles 6-9 -> in_ready falls once 5 entries are held. All 10 results arrive in tag order with correct values. Held output stays stable during the stall.
- clrn pulsed low with 3 ops in flight -> out_valid 0 asynchronously. No stale result appears after release. The next op appears 5 cycles after its accept.
- REG_EVERY=5 build: same vectors give identical results at latency 1. Random op/sa/data checked against a reference model for 10k operations with random out_ready.
